sal_rw_sched: RTL and testbench
===============================

# sal_rw_sched

Request scheduler sitting between the AXI slave front-end and the per-bank controllers. Arbitrates the AR and AW address channels with read priority and bounded write starvation, only issues a write once its full data burst has landed, decodes the bank address, and presents each winning request to exactly one bank controller through a registered one-entry output stage.

## Interface
- WR_STARVE_LIMIT, 8: cycles an eligible write may wait while reads win before the scheduler forces write mode.
- WR_BURST_MAX, 4: max consecutive writes granted in write mode before reads are reconsidered.
- WR_HIGH_WM, 12: buffered-burst count that forces write mode regardless of read traffic.
- WCNT_WIDTH, 5: width of the buffered-write-burst counter.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- axi_ar_if  AXI_A_IF.DST  read address channel (aid, aaddr, alen, avalid in; aready out).
- axi_aw_if  AXI_A_IF.DST  write address channel, same fields.
- axi_w_if  AXI_W_IF  monitor only: wvalid, wready, wlast sampled; block drives nothing on it.
- bk_req_if_arr[`DRAM_BK_CNT]  BK_REQ_IF.SRC  per-bank request (id, ra, ca, len, wr, valid out; ready in).
- wcnt_ovf  out  1  sticky error: a wlast handshake arrived with counter at all-ones.

## Operation
- wcnt: +1 on wlast handshake (wvalid&wready&wlast), -1 on AW accept, unchanged when both or neither. Saturates at 2^WCNT_WIDTH-1 (sets wcnt_ovf); never decrements below 0 (AW is never accepted at 0).
- wr_elig = axi_aw_if.avalid & (wcnt != 0). rd_elig = axi_ar_if.avalid.
- FSM states RD_MODE (reset), WR_MODE.
  - RD_MODE: grant AR if rd_elig. Go to WR_MODE when wr_elig and (!rd_elig or starve_cnt >= WR_STARVE_LIMIT or wcnt >= WR_HIGH_WM). starve_cnt increments each cycle wr_elig is true in RD_MODE and no write is granted; clears on entering WR_MODE or when !wr_elig.
  - WR_MODE: grant AW if wr_elig. burst_cnt counts AW accepts. Return to RD_MODE when !wr_elig, or burst_cnt reaches WR_BURST_MAX with rd_elig; burst_cnt clears on entry.
  - Transition takes effect next cycle; the granting decision in a cycle uses current state only.
- Output slot: one entry {ba, id, ra, ca, len, wr}, ba/ra/ca from shared decode functions on aaddr. slot_free = !slot_vld | bk_req_if_arr[slot_ba].ready.
- aready of granted channel = slot_free; other channel aready = 0. Accept = avalid & aready loads slot.
- Only bk_req_if_arr[slot_ba].valid = slot_vld; all other banks valid = 0; payload may be broadcast to all banks.
- Slot holds stable until the addressed bank's ready; back-to-back issue when drain and load coincide.

## Timing
- Reset: all aready 0, all bank valid 0, wcnt 0, starve/burst counters 0, state RD_MODE, wcnt_ovf 0.
- Latency AXI accept -> bank valid: 1 cycle; full throughput 1 request/cycle when banks ready.
- wlast landing in cycle N makes a write eligible in cycle N+1 (no combinational bypass).
- aready depends combinationally on the bank ready of the current slot; no combinational path from avalid to aready.
- Reset mid-transfer discards the slot without a bank handshake.

## Structure
- Shared package: sched_mode_e {RD_MODE, WR_MODE}, bank-request payload struct, get_dram_ba/ra/ca functions.
- Sub-module sal_bk_req_slot: one-entry output register plus bank demux of valid/ready.

## Test plan
- Reads only, banks always ready: 8 ARs to banks 0..7 -> each bank sees valid one cycle after its accept, 1/cycle, wr=0.
- AW valid with wcnt=0 for 20 cycles, then wlast handshake -> AW aready stays 0 until cycle after wlast, then write issued with wr=1, wcnt back to 0.
- Continuous ARs plus one eligible write -> write granted after exactly WR_STARVE_LIMIT(8) starve cycles plus mode switch.
- 6 eligible writes with continuous reads in WR_MODE -> exactly 4 writes, then reads resume.
- Bank 3 ready held low 5 cycles with slot targeting bank 3 -> slot payload stable, both areadys 0, no other bank valid; issue resumes on ready.
- Simultaneous AW accept and wlast handshake at wcnt=2 -> wcnt stays 2; 32 wlasts with no AW -> wcnt 31, wcnt_ovf=1.

Source files
------------

// File: rtl/sal_rw_sched_pkg.sv
// Shared types and address decode for the read/write request scheduler.
`ifndef DRAM_BK_CNT
`define DRAM_BK_CNT 8
`endif

package sal_rw_sched_pkg;

    localparam int BK_CNT = `DRAM_BK_CNT;
    localparam int BA_W   = $clog2(BK_CNT);
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 8;
    localparam int OFS_W  = 3;
    localparam int CA_W   = 10;
    localparam int RA_W   = ADDR_W - BA_W - CA_W - OFS_W;

    typedef enum logic {
        RD_MODE,
        WR_MODE
    } sched_mode_e;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [RA_W-1:0]  ra;
        logic [CA_W-1:0]  ca;
        logic [LEN_W-1:0] len;
        logic             wr;
    } bk_req_t;

    // aaddr = {ra, ba, ca, byte offset}
    function automatic logic [BA_W-1:0] get_dram_ba(input logic [ADDR_W-1:0] a);
        return a[OFS_W+CA_W +: BA_W];
    endfunction

    function automatic logic [RA_W-1:0] get_dram_ra(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: RA_W];
    endfunction

    function automatic logic [CA_W-1:0] get_dram_ca(input logic [ADDR_W-1:0] a);
        return a[OFS_W +: CA_W];
    endfunction

endpackage

// File: rtl/sal_rw_sched_if.sv
// AXI address/data-channel and per-bank request interfaces.
interface AXI_A_IF;
    import sal_rw_sched_pkg::*;

    logic [ID_W-1:0]   aid;
    logic [ADDR_W-1:0] aaddr;
    logic [LEN_W-1:0]  alen;
    logic              avalid;
    logic              aready;

    modport SRC (output aid, aaddr, alen, avalid, input aready);
    modport DST (input aid, aaddr, alen, avalid, output aready);
endinterface

interface AXI_W_IF;
    logic wvalid;
    logic wready;
    logic wlast;

    modport MON (input wvalid, wready, wlast);
endinterface

interface BK_REQ_IF;
    import sal_rw_sched_pkg::*;

    logic [ID_W-1:0]  id;
    logic [RA_W-1:0]  ra;
    logic [CA_W-1:0]  ca;
    logic [LEN_W-1:0] len;
    logic             wr;
    logic             valid;
    logic             ready;

    modport SRC (output id, ra, ca, len, wr, valid, input ready);
    modport DST (input id, ra, ca, len, wr, valid, output ready);
endinterface

// File: rtl/sal_bk_req_slot.sv
// One-entry registered output stage with bank demux of valid and ready.
module sal_bk_req_slot
    import sal_rw_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BA_W-1:0]   load_ba,
    input  bk_req_t           load_req,
    input  logic [BK_CNT-1:0] bk_ready,
    output logic [BK_CNT-1:0] bk_valid,
    output bk_req_t           slot_req,
    output logic              slot_free
);

    logic            slot_vld_q, slot_vld_d;
    logic [BA_W-1:0] slot_ba_q, slot_ba_d;
    bk_req_t         slot_q, slot_d;
    logic            drain;

    always_comb begin
        drain      = slot_vld_q & bk_ready[slot_ba_q];
        slot_free  = !slot_vld_q | bk_ready[slot_ba_q];
        slot_vld_d = (slot_vld_q & !drain) | load;
        slot_ba_d  = load ? load_ba : slot_ba_q;
        slot_d     = load ? load_req : slot_q;
        bk_valid   = '0;
        bk_valid[slot_ba_q] = slot_vld_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld_q <= 1'b0;
            slot_ba_q  <= '0;
            slot_q     <= '0;
        end else begin
            slot_vld_q <= slot_vld_d;
            slot_ba_q  <= slot_ba_d;
            slot_q     <= slot_d;
        end
    end

    assign slot_req = slot_q;

endmodule

// File: rtl/sal_rw_sched.sv
// AR/AW scheduler: read priority, bounded write starvation, bank issue.
`ifndef DRAM_BK_CNT
`define DRAM_BK_CNT 8
`endif

module sal_rw_sched
    import sal_rw_sched_pkg::*;
#(
    parameter int WR_STARVE_LIMIT = 8,
    parameter int WR_BURST_MAX    = 4,
    parameter int WR_HIGH_WM      = 12,
    parameter int WCNT_WIDTH      = 5
) (
    input  logic  clk,
    input  logic  rst_n,
    AXI_A_IF.DST  axi_ar_if,
    AXI_A_IF.DST  axi_aw_if,
    AXI_W_IF.MON  axi_w_if,
    BK_REQ_IF.SRC bk_req_if_arr[`DRAM_BK_CNT],
    output logic  wcnt_ovf
);

    localparam int SC_W = $clog2(WR_STARVE_LIMIT + 1);
    localparam int BC_W = $clog2(WR_BURST_MAX + 1);

    sched_mode_e           mode_q, mode_d;
    logic [WCNT_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [SC_W-1:0]       starve_q, starve_d;
    logic [BC_W-1:0]       burst_q, burst_d, burst_nxt;
    logic                  ovf_q, ovf_d;
    logic                  run_q, run_d;

    logic                  rd_elig, wr_elig, wlast_hs;
    logic                  ar_acc, aw_acc, load, slot_free, wr_sel;
    logic [ADDR_W-1:0]     sel_addr;
    logic [BA_W-1:0]       load_ba;
    bk_req_t               load_req, slot_req;
    logic [BK_CNT-1:0]     bk_ready, bk_valid;

    assign wlast_hs = axi_w_if.wvalid & axi_w_if.wready & axi_w_if.wlast;
    assign rd_elig  = axi_ar_if.avalid;
    assign wr_elig  = axi_aw_if.avalid & (wcnt_q != '0);
    assign wr_sel   = (mode_q == WR_MODE);

    // aready is built from state and bank ready only, never from avalid
    assign axi_ar_if.aready = run_q & !wr_sel & slot_free;
    assign axi_aw_if.aready = run_q & wr_sel & (wcnt_q != '0) & slot_free;

    assign ar_acc = axi_ar_if.avalid & axi_ar_if.aready;
    assign aw_acc = axi_aw_if.avalid & axi_aw_if.aready;
    assign load   = ar_acc | aw_acc;

    always_comb begin
        sel_addr     = wr_sel ? axi_aw_if.aaddr : axi_ar_if.aaddr;
        load_ba      = get_dram_ba(sel_addr);
        load_req.id  = wr_sel ? axi_aw_if.aid : axi_ar_if.aid;
        load_req.ra  = get_dram_ra(sel_addr);
        load_req.ca  = get_dram_ca(sel_addr);
        load_req.len = wr_sel ? axi_aw_if.alen : axi_ar_if.alen;
        load_req.wr  = wr_sel;
    end

    always_comb begin
        wcnt_d = wcnt_q;
        unique case ({wlast_hs, aw_acc})
            2'b10:   wcnt_d = (&wcnt_q) ? wcnt_q : wcnt_q + 1'b1;
            2'b01:   wcnt_d = wcnt_q - 1'b1;
            default: wcnt_d = wcnt_q;
        endcase
        ovf_d = ovf_q | (wlast_hs & (&wcnt_q));
        run_d = 1'b1;
    end

    always_comb begin
        mode_d    = mode_q;
        starve_d  = starve_q;
        burst_d   = burst_q;
        burst_nxt = burst_q;
        if (aw_acc && burst_q < BC_W'(WR_BURST_MAX))
            burst_nxt = burst_q + 1'b1;
        unique case (mode_q)
            RD_MODE: begin
                if (!wr_elig)
                    starve_d = '0;
                else if (starve_q < SC_W'(WR_STARVE_LIMIT))
                    starve_d = starve_q + 1'b1;
                if (wr_elig && (!rd_elig ||
                    starve_q >= SC_W'(WR_STARVE_LIMIT) ||
                    wcnt_q >= WCNT_WIDTH'(WR_HIGH_WM))) begin
                    mode_d   = WR_MODE;
                    starve_d = '0;
                    burst_d  = '0;
                end
            end
            WR_MODE: begin
                starve_d = '0;
                burst_d  = burst_nxt;
                // burst limit judged on the count including this cycle's accept
                if (!wr_elig ||
                    (burst_nxt >= BC_W'(WR_BURST_MAX) && rd_elig))
                    mode_d = RD_MODE;
            end
            default: mode_d = RD_MODE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= RD_MODE;
            wcnt_q   <= '0;
            starve_q <= '0;
            burst_q  <= '0;
            ovf_q    <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            wcnt_q   <= wcnt_d;
            starve_q <= starve_d;
            burst_q  <= burst_d;
            ovf_q    <= ovf_d;
            run_q    <= run_d;
        end
    end

    assign wcnt_ovf = ovf_q;

    sal_bk_req_slot u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_ba   (load_ba),
        .load_req  (load_req),
        .bk_ready  (bk_ready),
        .bk_valid  (bk_valid),
        .slot_req  (slot_req),
        .slot_free (slot_free)
    );

    for (genvar g = 0; g < BK_CNT; g++) begin : g_bk
        assign bk_ready[g]              = bk_req_if_arr[g].ready;
        assign bk_req_if_arr[g].valid   = bk_valid[g];
        assign bk_req_if_arr[g].id      = slot_req.id;
        assign bk_req_if_arr[g].ra      = slot_req.ra;
        assign bk_req_if_arr[g].ca      = slot_req.ca;
        assign bk_req_if_arr[g].len     = slot_req.len;
        assign bk_req_if_arr[g].wr      = slot_req.wr;
    end

endmodule

// File: tb/tb_sal_rw_sched.sv
// Directed bench for sal_rw_sched with hand-derived cycle expectations.
`ifndef DRAM_BK_CNT
`define DRAM_BK_CNT 8
`endif

module tb_sal_rw_sched;
    import sal_rw_sched_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wcnt_ovf;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    AXI_A_IF  ar_if ();
    AXI_A_IF  aw_if ();
    AXI_W_IF  w_if ();
    BK_REQ_IF bk_if[BK_CNT] ();

    logic [BK_CNT-1:0] bk_valid;
    logic [BK_CNT-1:0] bk_ready;
    logic [ID_W-1:0]   bk_id[BK_CNT];
    logic [RA_W-1:0]   bk_ra[BK_CNT];
    logic [CA_W-1:0]   bk_ca[BK_CNT];
    logic [LEN_W-1:0]  bk_len[BK_CNT];
    logic              bk_wr[BK_CNT];

    for (genvar g = 0; g < BK_CNT; g++) begin : g_bk
        assign bk_valid[g]    = bk_if[g].valid;
        assign bk_if[g].ready = bk_ready[g];
        assign bk_id[g]       = bk_if[g].id;
        assign bk_ra[g]       = bk_if[g].ra;
        assign bk_ca[g]       = bk_if[g].ca;
        assign bk_len[g]      = bk_if[g].len;
        assign bk_wr[g]       = bk_if[g].wr;
    end

    sal_rw_sched #(
        .WR_STARVE_LIMIT (8),
        .WR_BURST_MAX    (4),
        .WR_HIGH_WM      (12),
        .WCNT_WIDTH      (5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .axi_ar_if     (ar_if),
        .axi_aw_if     (aw_if),
        .axi_w_if      (w_if),
        .bk_req_if_arr (bk_if),
        .wcnt_ovf      (wcnt_ovf)
    );

    logic ar_hit[64];
    logic aw_hit[64];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [31:0] mk_addr(input int ba, input int ra,
                                            input int ca);
        logic [31:0] a;
        a        = '0;
        a[15:13] = ba[2:0];
        a[31:16] = ra[15:0];
        a[12:3]  = ca[9:0];
        return a;
    endfunction

    function automatic logic [BK_CNT-1:0] oh(input int b);
        logic [BK_CNT-1:0] m;
        m    = '0;
        m[b] = 1'b1;
        return m;
    endfunction

    task automatic drv_ar(input logic v, input int ba, input int id);
        ar_if.avalid = v;
        ar_if.aaddr  = mk_addr(ba, ba * 16 + 1, ba * 8 + 2);
        ar_if.aid    = 4'(id);
        ar_if.alen   = 8'(id);
    endtask

    task automatic drv_aw(input logic v, input int ba, input int id);
        aw_if.avalid = v;
        aw_if.aaddr  = mk_addr(ba, ba * 16 + 1, ba * 8 + 2);
        aw_if.aid    = 4'(id);
        aw_if.alen   = 8'(id);
    endtask

    task automatic wbeats(input int n);
        w_if.wvalid = 1'b1;
        w_if.wready = 1'b1;
        w_if.wlast  = 1'b1;
        repeat (n) nxt();
        w_if.wvalid = 1'b0;
        w_if.wready = 1'b0;
        w_if.wlast  = 1'b0;
    endtask

    task automatic run(input int n, input logic ar_on, input logic aw_on);
        for (int k = 0; k < n; k++) begin
            drv_ar(ar_on, k % 8, k);
            drv_aw(aw_on, (k + 3) % 8, k + 1);
            mid();
            ar_hit[k] = ar_if.avalid & ar_if.aready;
            aw_hit[k] = aw_if.avalid & aw_if.aready;
            nxt();
        end
        drv_ar(1'b0, 0, 0);
        drv_aw(1'b0, 0, 0);
    endtask

    function automatic int cnt_ar(input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++) c += int'(ar_hit[k]);
        return c;
    endfunction

    function automatic int cnt_aw(input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++) c += int'(aw_hit[k]);
        return c;
    endfunction

    function automatic int first_aw(input int n);
        for (int k = 0; k < n; k++) if (aw_hit[k]) return k;
        return 99;
    endfunction

    initial begin
        int n;
        bk_ready = '1;
        drv_ar(1'b0, 0, 0);
        drv_aw(1'b0, 0, 0);
        w_if.wvalid = 1'b0;
        w_if.wready = 1'b0;
        w_if.wlast  = 1'b0;
        for (int k = 0; k < 64; k++) begin
            ar_hit[k] = 1'b0;
            aw_hit[k] = 1'b0;
        end

        // reset state
        repeat (2) mid();
        chk("rst_ar_rdy", 32'(ar_if.aready), 0);
        chk("rst_aw_rdy", 32'(aw_if.aready), 0);
        chk("rst_bk_vld", 32'(bk_valid), 0);
        chk("rst_ovf", 32'(wcnt_ovf), 0);
        nxt();
        rst_n = 1'b1;
        nxt();

        // reads to banks 0..7, one per cycle
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drv_ar(1'b1, i, i);
            else drv_ar(1'b0, 0, 0);
            mid();
            if (i < 8) chk("rd_acc", 32'(ar_if.aready), 1);
            if (i > 0) begin
                chk("rd_bk_vld", 32'(bk_valid), 32'(oh(i - 1)));
                chk("rd_bk_id", 32'(bk_id[i-1]), i - 1);
                chk("rd_bk_ra", 32'(bk_ra[i-1]), (i - 1) * 16 + 1);
                chk("rd_bk_ca", 32'(bk_ca[i-1]), (i - 1) * 8 + 2);
                chk("rd_bk_len", 32'(bk_len[i-1]), i - 1);
                chk("rd_bk_wr", 32'(bk_wr[i-1]), 0);
            end
            nxt();
        end
        mid();
        chk("rd_idle_vld", 32'(bk_valid), 0);
        nxt();

        // write waits for its data burst
        drv_aw(1'b1, 2, 5);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            mid();
            if (aw_if.aready || bk_valid != '0) n++;
            nxt();
        end
        chk("wr_nodata_blocked", n, 0);
        w_if.wvalid = 1'b1;
        w_if.wready = 1'b1;
        w_if.wlast  = 1'b1;
        mid();
        chk("wr_rdy_wlast_cyc", 32'(aw_if.aready), 0);
        nxt();
        w_if.wvalid = 1'b0;
        w_if.wready = 1'b0;
        w_if.wlast  = 1'b0;
        mid();
        chk("wr_rdy_elig_cyc", 32'(aw_if.aready), 0);
        nxt();
        mid();
        chk("wr_acc", 32'(aw_if.aready), 1);
        nxt();
        drv_aw(1'b1, 6, 7);
        mid();
        chk("wr_bk_vld", 32'(bk_valid), 32'(oh(2)));
        chk("wr_bk_wr", 32'(bk_wr[2]), 1);
        chk("wr_bk_id", 32'(bk_id[2]), 5);
        chk("wr_bk_ra", 32'(bk_ra[2]), 33);
        nxt();
        run(6, 1'b0, 1'b1);
        chk("wr_credit_used", cnt_aw(0, 5), 0);

        // starvation bound under continuous reads
        wbeats(1);
        repeat (2) nxt();
        run(14, 1'b1, 1'b1);
        chk("starve_first_wr", first_aw(14), 9);
        chk("starve_rd_before", cnt_ar(0, 8), 9);
        chk("starve_rd_in_wr", cnt_ar(9, 10), 0);
        chk("starve_rd_resume", 32'(ar_hit[11]), 1);
        chk("starve_wr_total", cnt_aw(0, 13), 1);

        // write burst limit with reads pending
        wbeats(6);
        repeat (2) nxt();
        run(30, 1'b1, 1'b1);
        chk("burst_first_wr", first_aw(30), 9);
        chk("burst_wr_cnt", cnt_aw(9, 12), 4);
        chk("burst_rd_in_wr", cnt_ar(9, 12), 0);
        chk("burst_wr_after", 32'(aw_hit[13]), 0);
        chk("burst_rd_resume", cnt_ar(13, 21), 9);
        chk("burst_wr_second", cnt_aw(22, 23), 2);
        chk("burst_gap", 32'(ar_hit[24]), 0);
        chk("burst_rd_tail", cnt_ar(25, 29), 5);
        chk("burst_wr_total", cnt_aw(0, 29), 6);

        // bank 3 stalls the slot
        bk_ready[3] = 1'b0;
        drv_ar(1'b1, 3, 9);
        mid();
        chk("stall_acc", 32'(ar_if.aready), 1);
        nxt();
        drv_ar(1'b1, 4, 10);
        drv_aw(1'b1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("stall_bk_vld", 32'(bk_valid), 32'(oh(3)));
            chk("stall_bk_id", 32'(bk_id[3]), 9);
            chk("stall_bk_ra", 32'(bk_ra[3]), 49);
            chk("stall_ar_rdy", 32'(ar_if.aready), 0);
            chk("stall_aw_rdy", 32'(aw_if.aready), 0);
            nxt();
        end
        drv_aw(1'b0, 0, 0);
        bk_ready[3] = 1'b1;
        mid();
        chk("stall_release_acc", 32'(ar_if.aready), 1);
        nxt();
        drv_ar(1'b0, 0, 0);
        mid();
        chk("stall_next_vld", 32'(bk_valid), 32'(oh(4)));
        chk("stall_next_id", 32'(bk_id[4]), 10);
        nxt();

        // AW accept coincident with wlast at wcnt=2
        wbeats(2);
        nxt();
        drv_aw(1'b1, 5, 3);
        mid();
        chk("coinc_rd_mode", 32'(aw_if.aready), 0);
        nxt();
        w_if.wvalid = 1'b1;
        w_if.wready = 1'b1;
        w_if.wlast  = 1'b1;
        mid();
        chk("coinc_acc", 32'(aw_if.aready), 1);
        nxt();
        w_if.wvalid = 1'b0;
        w_if.wready = 1'b0;
        w_if.wlast  = 1'b0;
        run(8, 1'b0, 1'b1);
        chk("coinc_wcnt_kept", cnt_aw(0, 7), 2);

        // counter saturation and overflow flag
        wbeats(31);
        mid();
        chk("ovf_at_31", 32'(wcnt_ovf), 0);
        nxt();
        wbeats(1);
        mid();
        chk("ovf_at_32", 32'(wcnt_ovf), 1);
        nxt();
        run(40, 1'b0, 1'b1);
        chk("sat_drain_cnt", cnt_aw(0, 39), 31);
        mid();
        chk("ovf_sticky", 32'(wcnt_ovf), 1);
        nxt();

        // reset discards a pending slot
        bk_ready[5] = 1'b0;
        drv_ar(1'b1, 5, 2);
        nxt();
        drv_ar(1'b0, 0, 0);
        mid();
        chk("rstmid_pending", 32'(bk_valid), 32'(oh(5)));
        nxt();
        rst_n = 1'b0;
        #1;
        chk("rstmid_vld", 32'(bk_valid), 0);
        chk("rstmid_ovf", 32'(wcnt_ovf), 0);
        nxt();
        rst_n = 1'b1;
        bk_ready = '1;
        repeat (2) nxt();
        mid();
        chk("rstmid_after", 32'(bk_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
